// File: rtl/lpc_frame_ctrl.sv
// LPC encoder frame sequencer: ping-pong write tracking, per-frame LDR/freq-scan/latch sequence.
// Optional LPC_FRAME_CTRL_STATS_EN adds frames_done / frames_dropped counters.
module lpc_frame_ctrl #(
    parameter int AW      = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          v,
    input  logic [AW-1:0] rate,
    input  logic          ldr_done,
    input  logic          clr,
    output logic [AW:0]   wr_addr,
    output logic [AW:0]   rd_addr,
    output logic          frame_end,
    output logic          thr_load,
    output logic          peak_rst,
    output logic          peak_v,
    output logic          ldr_rst,
    output logic          ldr_start,
    output logic          freq_rst,
    output logic          freq_v,
    output logic          latch,
    output logic          busy,
    output logic          overrun,
`ifdef LPC_FRAME_CTRL_STATS_EN
    output logic [15:0]   frames_done,
    output logic [15:0]   frames_dropped,
`endif
    output logic          timeout
);

    // state  | meaning
    // IDLE   | waiting for a frame boundary
    // RST    | one-cycle reset of peak, LDR and freq estimator
    // LDR    | LDR solve running, timeout counter armed
    // FREQ   | scanning the read bank, one address per cycle
    // LATCH  | one-cycle coefficient latch
    typedef enum logic [2:0] {S_IDLE, S_RST, S_LDR, S_FREQ, S_LATCH} state_t;

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic [AW-1:0] rate_q;
    logic [AW-1:0] rate_clamp;
    logic [AW-1:0] rate_eff;
    logic [AW-1:0] rd_len;
    logic          rate_ld;
    logic          rd_bank;
    logic [TW-1:0] tmo;
    logic          sample_acc;
    logic          boundary;
    logic          tmo_exp;
    logic          idle_next;

    assign rate_clamp = (rate == '0) ? AW'(1) : rate;
    // rate_q is not yet loaded in the first cycle after reset release
    assign rate_eff   = rate_ld ? rate_q : rate_clamp;
    assign sample_acc = v & enable;
    assign boundary   = sample_acc & (wr_addr[AW-1:0] == rate_eff);
    assign tmo_exp    = (state == S_LDR) & ~ldr_done & (tmo == '0);
    // FSM will be IDLE when this boundary's frame_end is seen, so the frame is accepted
    assign idle_next  = ((state == S_IDLE) & ~frame_end) | (state == S_LATCH) | tmo_exp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_addr   <= '0;
            rate_q    <= '0;
            rate_ld   <= 1'b0;
            frame_end <= 1'b0;
            thr_load  <= 1'b0;
            peak_v    <= 1'b0;
            rd_bank   <= 1'b0;
            rd_len    <= '0;
        end else begin
            frame_end <= 1'b0;
            thr_load  <= 1'b0;
            peak_v    <= enable;
            if (!rate_ld) begin
                rate_q  <= rate_clamp;
                rate_ld <= 1'b1;
            end
            if (sample_acc) begin
                if (boundary) begin
                    wr_addr   <= {~wr_addr[AW], {AW{1'b0}}};
                    frame_end <= 1'b1;
                    rate_q    <= rate_clamp;
                    rate_ld   <= 1'b1;
                    if (idle_next) begin
                        thr_load <= 1'b1;
                        rd_bank  <= wr_addr[AW];
                        rd_len   <= rate_eff;
                    end
                end else begin
                    wr_addr[AW-1:0] <= wr_addr[AW-1:0] + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            rd_addr   <= '0;
            peak_rst  <= 1'b0;
            ldr_rst   <= 1'b0;
            ldr_start <= 1'b0;
            freq_rst  <= 1'b0;
            freq_v    <= 1'b0;
            latch     <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            timeout   <= 1'b0;
            tmo       <= '0;
`ifdef LPC_FRAME_CTRL_STATS_EN
            frames_done    <= '0;
            frames_dropped <= '0;
`endif
        end else begin
            // clear first so a same-cycle set below takes priority
            if (clr) begin
                overrun <= 1'b0;
                timeout <= 1'b0;
            end
            if (frame_end && state != S_IDLE) begin
                overrun <= 1'b1;
`ifdef LPC_FRAME_CTRL_STATS_EN
                frames_dropped <= frames_dropped + 16'd1;
`endif
            end
            case (state)
                S_IDLE: begin
                    if (frame_end) begin
                        state    <= S_RST;
                        peak_rst <= 1'b1;
                        ldr_rst  <= 1'b1;
                        freq_rst <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_RST: begin
                    peak_rst  <= 1'b0;
                    ldr_rst   <= 1'b0;
                    freq_rst  <= 1'b0;
                    ldr_start <= 1'b1;
                    tmo       <= TW'(TIMEOUT - 1);
                    state     <= S_LDR;
                end
                S_LDR: begin
                    if (ldr_done) begin
                        ldr_start <= 1'b0;
                        freq_v    <= 1'b1;
                        rd_addr   <= {rd_bank, {AW{1'b0}}};
                        state     <= S_FREQ;
                    end else if (tmo == '0) begin
                        ldr_start <= 1'b0;
                        timeout   <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        tmo <= tmo - TW'(1);
                    end
                end
                S_FREQ: begin
                    if (rd_addr[AW-1:0] == rd_len) begin
                        freq_v <= 1'b0;
                        latch  <= 1'b1;
                        state  <= S_LATCH;
                    end else begin
                        rd_addr[AW-1:0] <= rd_addr[AW-1:0] + AW'(1);
                    end
                end
                S_LATCH: begin
                    latch <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
`ifdef LPC_FRAME_CTRL_STATS_EN
                    frames_done <= frames_done + 16'd1;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lpc_frame_ctrl.sv
// Self-checking bench for lpc_frame_ctrl; freq-scan addresses go through an expected-address queue.
module tb_lpc_frame_ctrl;
    localparam int AW  = 8;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          v = 1'b0;
    logic [AW-1:0] rate = 8'd3;
    logic          ldr_done = 1'b0;
    logic          clr = 1'b0;
    logic [AW:0]   wr_addr, rd_addr;
    logic          frame_end, thr_load, peak_rst, peak_v, ldr_rst, ldr_start;
    logic          freq_rst, freq_v, latch, busy, overrun, timeout;
`ifdef LPC_FRAME_CTRL_STATS_EN
    logic [15:0]   frames_done, frames_dropped;
`endif
    logic [2*AW+13:0] all_out;

    int checks = 0;
    int errors = 0;
    int ldr_delay = 0;
    int ldr_cnt = 0;
    int n_busy = 0, n_ldr = 0, n_rst = 0, n_latch = 0, n_fe = 0, n_thr = 0;
    int exp_done = 0, exp_drop = 0;
    logic [AW:0] exp_q[$];
    logic wb = 1'b0;

    always #5 clk = ~clk;

    assign all_out = {wr_addr, rd_addr, frame_end, thr_load, peak_rst, peak_v, ldr_rst,
                      ldr_start, freq_rst, freq_v, latch, busy, overrun, timeout};

    lpc_frame_ctrl #(.AW(AW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .enable(enable), .v(v), .rate(rate), .ldr_done(ldr_done),
        .clr(clr), .wr_addr(wr_addr), .rd_addr(rd_addr), .frame_end(frame_end),
        .thr_load(thr_load), .peak_rst(peak_rst), .peak_v(peak_v), .ldr_rst(ldr_rst),
        .ldr_start(ldr_start), .freq_rst(freq_rst), .freq_v(freq_v), .latch(latch),
        .busy(busy), .overrun(overrun),
`ifdef LPC_FRAME_CTRL_STATS_EN
        .frames_done(frames_done), .frames_dropped(frames_dropped),
`endif
        .timeout(timeout)
    );

    // One clock: observe at the falling edge, pop scan addresses, then play the LDR solver.
    task automatic cycle();
        logic [AW:0] e;
        @(negedge clk);
        if (busy === 1'b1) n_busy++;
        if (ldr_start === 1'b1) n_ldr++;
        if (ldr_rst === 1'b1) n_rst++;
        if (latch === 1'b1) n_latch++;
        if (frame_end === 1'b1) n_fe++;
        if (thr_load === 1'b1) n_thr++;
        if (freq_v === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL freq_scan: rd_addr=%h but no address expected", rd_addr);
            end else begin
                e = exp_q.pop_front();
                if (rd_addr !== e) begin
                    errors++;
                    $display("FAIL freq_scan: rd_addr got %h expected %h", rd_addr, e);
                end
            end
        end
        if (ldr_start === 1'b1) begin
            ldr_cnt++;
            if (ldr_delay != 0 && ldr_cnt == ldr_delay) ldr_done = 1'b1;
        end else begin
            ldr_cnt  = 0;
            ldr_done = 1'b0;
        end
    endtask

    task automatic sample();
        v = 1'b1;
        cycle();
        v = 1'b0;
    endtask

    task automatic push_scan(input logic bank, input int len);
        for (int i = 0; i <= len; i++) exp_q.push_back({bank, AW'(i)});
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b0; v = 1'b0; rate = 8'd3;
        cycle(); cycle();
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        rst = 1'b1; enable = 1'b1;
        cycle(); cycle();
        checks++;
        if (wr_addr !== '0 || busy !== 1'b0 || peak_v !== 1'b1) begin
            errors++; $display("FAIL post_reset: wr_addr=%h busy=%b peak_v=%b expected 000/0/1", wr_addr, busy, peak_v);
        end
    endtask

    task automatic test_frame();
        int s_busy, s_ldr, s_rst, s_latch;
        s_busy = n_busy; s_ldr = n_ldr; s_rst = n_rst; s_latch = n_latch;
        ldr_delay = 10; rate = 8'd3;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_addr !== {wb, AW'(i)}) begin
                errors++; $display("FAIL wr_seq: wr_addr got %h expected %h", wr_addr, {wb, AW'(i)});
            end
            if (i == 3) push_scan(wb, 3);
            sample();
            if (i < 3) repeat (3) cycle();
        end
        wb = ~wb;
        checks++;
        if (wr_addr !== 9'h100 || frame_end !== 1'b1 || thr_load !== 1'b1) begin
            errors++; $display("FAIL frame_boundary: wr_addr=%h frame_end=%b thr_load=%b expected 100/1/1", wr_addr, frame_end, thr_load);
        end
        repeat (24) cycle();
        checks++;
        if (n_busy - s_busy != 16) begin
            errors++; $display("FAIL busy_len: got %0d cycles expected 16", n_busy - s_busy);
        end
        checks++;
        if (n_ldr - s_ldr != 10 || n_rst - s_rst != 1 || n_latch - s_latch != 1) begin
            errors++; $display("FAIL seq_pulses: ldr_start=%0d ldr_rst=%0d latch=%0d expected 10/1/1", n_ldr - s_ldr, n_rst - s_rst, n_latch - s_latch);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scan_count_1: %0d addresses left expected 0", exp_q.size());
        end
        exp_done++;
    endtask

    task automatic test_timeout_overrun();
        int s_ldr, s_rst, s_latch, s_fe, s_thr;
        s_ldr = n_ldr; s_rst = n_rst; s_latch = n_latch; s_fe = n_fe; s_thr = n_thr;
        ldr_delay = 0; rate = 8'd3;
        for (int i = 0; i < 8; i++) sample();
        wb = ~wb; wb = ~wb;
        checks++;
        if (wr_addr !== {wb, 8'h00}) begin
            errors++; $display("FAIL overrun_bank: wr_addr got %h expected %h", wr_addr, {wb, 8'h00});
        end
        cycle();
        exp_drop++;
        checks++;
        if (overrun !== 1'b1) begin
            errors++; $display("FAIL overrun_set: got %b expected 1", overrun);
        end
        repeat (70) cycle();
        checks++;
        if (timeout !== 1'b1 || busy !== 1'b0 || n_latch - s_latch != 0) begin
            errors++; $display("FAIL timeout_abort: timeout=%b busy=%b latches=%0d expected 1/0/0", timeout, busy, n_latch - s_latch);
        end
        checks++;
        if (n_ldr - s_ldr != TMO) begin
            errors++; $display("FAIL timeout_len: ldr_start %0d cycles expected %0d", n_ldr - s_ldr, TMO);
        end
        checks++;
        if (n_rst - s_rst != 1 || n_thr - s_thr != 1 || n_fe - s_fe != 2) begin
            errors++; $display("FAIL dropped_frame: ldr_rst=%0d thr_load=%0d frame_end=%0d expected 1/1/2", n_rst - s_rst, n_thr - s_thr, n_fe - s_fe);
        end
    endtask

    task automatic test_done_at_expiry();
        int s_ldr, s_latch;
        clr = 1'b1; cycle(); clr = 1'b0;
        checks++;
        if (overrun !== 1'b0 || timeout !== 1'b0) begin
            errors++; $display("FAIL clr_flags: overrun=%b timeout=%b expected 0/0", overrun, timeout);
        end
        s_ldr = n_ldr; s_latch = n_latch;
        ldr_delay = TMO;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) push_scan(wb, 3);
            sample();
        end
        wb = ~wb;
        repeat (80) cycle();
        exp_done++;
        checks++;
        if (timeout !== 1'b0 || n_ldr - s_ldr != TMO || n_latch - s_latch != 1) begin
            errors++; $display("FAIL done_wins: timeout=%b ldr_cycles=%0d latches=%0d expected 0/%0d/1", timeout, n_ldr - s_ldr, n_latch - s_latch, TMO);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scan_count_3: %0d addresses left expected 0", exp_q.size());
        end
    endtask

    task automatic test_enable();
        int s_fe;
        ldr_delay = 3;
        sample(); sample();
        s_fe = n_fe;
        enable = 1'b0;
        cycle();
        sample(); sample(); sample();
        checks++;
        if (wr_addr !== {wb, 8'h02} || n_fe - s_fe != 0 || peak_v !== 1'b0) begin
            errors++; $display("FAIL enable_hold: wr_addr=%h frame_ends=%0d peak_v=%b expected %h/0/0", wr_addr, n_fe - s_fe, peak_v, {wb, 8'h02});
        end
        enable = 1'b1;
        cycle();
        push_scan(wb, 3);
        sample(); sample();
        wb = ~wb;
        checks++;
        if (frame_end !== 1'b1 || wr_addr !== {wb, 8'h00}) begin
            errors++; $display("FAIL enable_resume: frame_end=%b wr_addr=%h expected 1/%h", frame_end, wr_addr, {wb, 8'h00});
        end
        repeat (15) cycle();
        exp_done++;
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scan_count_en: %0d addresses left expected 0", exp_q.size());
        end
    endtask

    task automatic test_rate_change();
        int s_fe;
        ldr_delay = 3; rate = 8'd3;
        sample(); sample();
        rate = 8'd5;
        sample();
        push_scan(wb, 3);
        sample();
        wb = ~wb;
        checks++;
        if (frame_end !== 1'b1 || wr_addr !== {wb, 8'h00}) begin
            errors++; $display("FAIL rate_old_frame: frame_end=%b wr_addr=%h expected 1/%h", frame_end, wr_addr, {wb, 8'h00});
        end
        repeat (15) cycle();
        exp_done++;
        s_fe = n_fe;
        for (int i = 0; i < 5; i++) sample();
        checks++;
        if (wr_addr !== {wb, 8'h05} || n_fe - s_fe != 0) begin
            errors++; $display("FAIL rate_new_frame: wr_addr=%h frame_ends=%0d expected %h/0", wr_addr, n_fe - s_fe, {wb, 8'h05});
        end
        push_scan(wb, 5);
        sample();
        wb = ~wb;
        checks++;
        if (frame_end !== 1'b1 || wr_addr !== {wb, 8'h00}) begin
            errors++; $display("FAIL rate_new_end: frame_end=%b wr_addr=%h expected 1/%h", frame_end, wr_addr, {wb, 8'h00});
        end
        repeat (20) cycle();
        exp_done++;
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scan_count_4: %0d addresses left expected 0", exp_q.size());
        end
    endtask

    task automatic test_async_reset();
        int s_fe;
        ldr_delay = 0; rate = 8'd2;
        for (int i = 0; i < 6; i++) sample();
        repeat (4) cycle();
        checks++;
        if (ldr_start !== 1'b1) begin
            errors++; $display("FAIL pre_reset_ldr: ldr_start got %b expected 1", ldr_start);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL async_reset: outputs got %h expected 0", all_out);
        end
`ifdef LPC_FRAME_CTRL_STATS_EN
        checks++;
        if (frames_done !== 16'd0 || frames_dropped !== 16'd0) begin
            errors++; $display("FAIL stats_reset: done=%0d dropped=%0d expected 0/0", frames_done, frames_dropped);
        end
`endif
        exp_done = 0; exp_drop = 0; wb = 1'b0;
        cycle(); cycle();
        rst = 1'b1;
        cycle();
        s_fe = n_fe;
        sample(); sample();
        checks++;
        if (wr_addr !== 9'h002 || n_fe - s_fe != 0) begin
            errors++; $display("FAIL reset_first_frame: wr_addr=%h frame_ends=%0d expected 002/0", wr_addr, n_fe - s_fe);
        end
        ldr_delay = 2;
        push_scan(wb, 2);
        sample();
        wb = ~wb;
        checks++;
        if (frame_end !== 1'b1 || wr_addr !== 9'h100) begin
            errors++; $display("FAIL reset_frame_end: frame_end=%b wr_addr=%h expected 1/100", frame_end, wr_addr);
        end
        repeat (15) cycle();
        exp_done++;
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scan_count_5: %0d addresses left expected 0", exp_q.size());
        end
    endtask

    task automatic test_overrun_clr();
        int s_rst, s_latch;
        s_rst = n_rst; s_latch = n_latch;
        ldr_delay = 20; rate = 8'd0;
        push_scan(wb, 2);
        sample(); sample(); sample();
        wb = ~wb;
        sample();
        checks++;
        if (wr_addr !== {wb, 8'h01} || frame_end !== 1'b0) begin
            errors++; $display("FAIL rate_clamp: wr_addr=%h frame_end=%b expected %h/0", wr_addr, frame_end, {wb, 8'h01});
        end
        sample();
        wb = ~wb;
        cycle();
        exp_drop++;
        checks++;
        if (overrun !== 1'b1 || wr_addr !== {wb, 8'h00}) begin
            errors++; $display("FAIL overrun_b: overrun=%b wr_addr=%h expected 1/%h", overrun, wr_addr, {wb, 8'h00});
        end
        clr = 1'b1; cycle(); clr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++; $display("FAIL clr_overrun: got %b expected 0", overrun);
        end
        sample(); sample();
        wb = ~wb;
        clr = 1'b1; cycle(); clr = 1'b0;
        exp_drop++;
        checks++;
        if (overrun !== 1'b1) begin
            errors++; $display("FAIL set_beats_clr: overrun got %b expected 1", overrun);
        end
        clr = 1'b1; cycle(); clr = 1'b0;
        repeat (40) cycle();
        exp_done++;
        checks++;
        if (n_rst - s_rst != 1 || n_latch - s_latch != 1 || timeout !== 1'b0 || overrun !== 1'b0) begin
            errors++; $display("FAIL overrun_run: ldr_rst=%0d latches=%0d timeout=%b overrun=%b expected 1/1/0/0", n_rst - s_rst, n_latch - s_latch, timeout, overrun);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scan_count_6: %0d addresses left expected 0", exp_q.size());
        end
`ifdef LPC_FRAME_CTRL_STATS_EN
        checks++;
        if (frames_done !== 16'(exp_done) || frames_dropped !== 16'(exp_drop)) begin
            errors++; $display("FAIL stats: done=%0d dropped=%0d expected %0d/%0d", frames_done, frames_dropped, exp_done, exp_drop);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_frame();
        test_timeout_overrun();
        test_done_at_expiry();
        test_enable();
        test_rate_change();
        test_async_reset();
        test_overrun_clr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lpc_frame_ctrl.md
Name: lpc_frame_ctrl

Overview:
Frame sequencer for the LPC encoder datapath, in a single clock domain.
- Tracks sample writes into a ping-pong sample buffer and detects frame boundaries.
- Per frame, runs a fixed sequence: snapshot peak threshold, reset, Levinson-Durbin (LDR) solve, frequency-estimator buffer scan, coefficient latch.
- Replaces the level/edge-triggered ad-hoc sequencing with one explicit FSM, plus overrun and timeout detection.

Parameters:
AW, 8, sample buffer address width per bank (max frame 2^AW samples)
TIMEOUT, 1023, max clk cycles allowed in LDR state before abort

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
enable  in  1  1: accept samples; 0: wr_addr frozen, in-flight frame processing still completes
v  in  1  sample strobe, one clk pulse per sample
rate  in  AW  frame length minus 1
ldr_done  in  1  LDR solution ready (level)
clr  in  1  synchronous clear of sticky flags
wr_addr  out  AW+1  buffer write address; MSB = write bank
rd_addr  out  AW+1  buffer read address for freq estimator; MSB = read bank
frame_end  out  1  one-cycle pulse at frame boundary
thr_load  out  1  one-cycle pulse: datapath registers peak>>>2 as threshold
peak_rst  out  1  one-cycle peak detector reset
peak_v  out  1  peak detector enable (= enable, registered)
ldr_rst  out  1  one-cycle LDR reset
ldr_start  out  1  LDR start, level, held until done/timeout
freq_rst  out  1  one-cycle freq estimator reset
freq_v  out  1  freq estimator sample valid
latch  out  1  one-cycle pulse: register A0..A10, voiced, freq_count
busy  out  1  FSM not IDLE
overrun  out  1  sticky: frame boundary while busy
timeout  out  1  sticky: LDR exceeded TIMEOUT

Behaviour:
- Reset (rst=0, async): all outputs 0; state IDLE; rate_q=rate clamped to ≥1 on first clk after release; bank=0.
- rate_q = max(rate,1), sampled only at a frame boundary; a mid-frame rate change affects the next frame only.
- Write counter: on v & enable:
  - wr_addr[AW-1:0]==rate_q → low bits to 0, bank toggles, frame_end=1 next cycle, rate_q reloaded;
  - otherwise low bits +1.
- The frame_end cycle also asserts thr_load. On an accepted frame, rd bank := old write bank and rd_len := old rate_q.
- FSM (accepts frame_end only in IDLE):
  - IDLE: frame_end → RST.
  - RST (1 cycle): ldr_rst=freq_rst=peak_rst=1 → LDR.
  - LDR: ldr_start=1; tmo counter +1 per cycle.
    - ldr_done → FREQ.
    - tmo==TIMEOUT-1 without done → timeout=1, IDLE, no latch.
    - ldr_done in the expiry cycle: done wins.
  - FREQ: freq_v=1; rd_addr low bits 0..rd_len, one per cycle (rd_len+1 cycles); last address → LATCH.
  - LATCH (1 cycle): latch=1 → IDLE.
- busy=1 in RST, LDR, FREQ and LATCH.
- Overrun: frame_end while state≠IDLE (including LATCH):
  - overrun=1;
  - frame dropped: no restart, no thr_load effect on the run in progress (thr_load suppressed);
  - the write bank still toggles.
- Sticky flags: set dominates clr in the same cycle; clr otherwise zeroes overrun/timeout.
- enable=0 mid-frame: wr_addr holds, no frame_end; resumes on re-enable.
- Ping-pong guarantees read bank ≠ write bank while FREQ runs, provided no overrun occurs.

Optional Feature:
LPC_FRAME_CTRL_STATS_EN
- Defined: adds outputs frames_done[15:0] (+1 per LATCH) and frames_dropped[15:0] (+1 per overrun event, counted even when the flag is already set). Both wrap at 16'hFFFF→0, reset to 0, and are not affected by clr.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. AW=8, rate=3, v every 4 clks, ldr_done 10 cycles after ldr_start rises → wr_addr 0,1,2,3 then 9'h100; frame_end 1 cycle after 4th v; RST 1 cycle; ldr_start 10 cycles; freq_v 4 cycles with rd_addr 0,1,2,3 (bank 0); latch pulse; busy high 16 cycles.
2. rate=3, v every clk, ldr_done held 0, TIMEOUT=64 → second frame_end during LDR gives overrun=1, no second RST; timeout=1 after 64 LDR cycles; state IDLE, latch never pulses.
3. ldr_done rises exactly at LDR cycle 64 with TIMEOUT=64 → FREQ entered, timeout stays 0.
4. rate 3→5 after 2 samples of a frame → current frame ends at wr_addr low=3, next at 5; freq scan of the first frame is 4 addresses.
5. rst low mid-LDR → all outputs 0 asynchronously (before next clk edge), wr_addr=0; after release, first frame_end after rate_q+1 samples.
6. overrun=1 with clr=1 → cleared next cycle; clr coincident with a new overrun → stays 1. With STATS_EN: frames_done=2 after two clean frames, frames_dropped counts each overrun.
